led_pattern_seq: RTL and testbench

//   Parametrised LED pattern sequencer. It drives the board LED bank from a

---
 rtl/led_pattern_seq.sv | 155 +++++++++++++++
 tb/tb_led_pattern_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: LED bank pattern sequencer.
// A switch-selected base pattern is shown on the LEDs either statically or
// animated (rotate, ping-pong, blink). Animation steps are paced by an
// internal prescaler, and each applied step is flagged on the tick output.
module led_pattern_seq #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] LED,
    output logic             tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_ROTATE   = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_BLINK    = 2'b11
    } mode_t;

    // Two-stage synchronisers for the asynchronous slide switches
    logic [1:0]       mode_meta_q;
    logic [1:0]       mode_s_q;
    logic [WIDTH-1:0] base_meta_q;
    logic [WIDTH-1:0] base_s_q;

    // Sequencer state
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_d;
    logic             dir_q;
    logic             dir_d;
    logic             tick_q;
    logic             tick_d;

    // Decoded events for the current cycle
    logic             reload;
    logic             cnt_wrap;
    logic             step;

    // Synchronise mode and base switches into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta_q <= '0;
            mode_s_q    <= '0;
            base_meta_q <= '0;
            base_s_q    <= '0;
        end else begin
            mode_meta_q <= mode;
            mode_s_q    <= mode_meta_q;
            base_meta_q <= base;
            base_s_q    <= base_meta_q;
        end
    end

    // Reload/step decode plus next-state for prescaler, pattern and direction
    always_comb begin
        reload   = load | (mode_s_q != mode_q);
        cnt_wrap = (cnt_q == CNT_MAX);
        step     = en & ~reload & cnt_wrap;

        mode_d = mode_s_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        dir_d  = dir_q;
        tick_d = 1'b0;

        if (reload) begin
            // A reload restarts the animation from the base pattern and
            // swallows any step that would have fired this cycle.
            cnt_d = '0;
            led_d = base_s_q;
            dir_d = 1'b0;
        end else begin
            if (en) begin
                cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            end
            // The strobe pulses on every prescaler wrap, even in STATIC.
            tick_d = step;

            case (mode_t'(mode_s_q))
                MODE_STATIC: begin
                    // Follow the switches continuously, independent of en.
                    led_d = base_s_q;
                end
                MODE_ROTATE: begin
                    if (step) begin
                        led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    end
                end
                MODE_PINGPONG: begin
                    if (step) begin
                        if (!dir_q) begin
                            // Walking toward MSB: bounce once the MSB is lit.
                            if (led_q[WIDTH-1]) begin
                                dir_d = 1'b1;
                                led_d = led_q >> 1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            // Walking toward LSB: bounce once the LSB is lit.
                            if (led_q[0]) begin
                                dir_d = 1'b0;
                                led_d = led_q << 1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                end
                MODE_BLINK: begin
                    if (step) begin
                        led_d = ~led_q;
                    end
                end
                default: begin
                    led_d = led_q;
                end
            endcase
        end
    end

    // Register sequencer state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            cnt_q  <= '0;
            led_q  <= '0;
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign LED  = led_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed scenarios plus randomized traffic for
// led_pattern_seq, checked every cycle against a behavioural model.
module tb_led_pattern_seq;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int FULL     = 1 << WIDTH;
    localparam int TOP      = 1 << (WIDTH - 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] base = '0;
    logic [WIDTH-1:0] LED;
    logic             tick;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    led_pattern_seq #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .load (load),
        .mode (mode),
        .base (base),
        .LED  (LED),
        .tick (tick)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_led = 0, m_dir = 0, m_cnt = 0, m_tick = 0;
    int m_mode_a = 0, m_mode_b = 0, m_mode_prev = 0;
    int m_base_a = 0, m_base_b = 0;
    int n_led, n_dir, n_cnt, n_tick;

    function automatic void model_next(input int led, input int dir, input int cnt,
                                       input int ms, input int bs, input int ld,
                                       input int e, input int prev,
                                       output int o_led, output int o_dir,
                                       output int o_cnt, output int o_tick);
        o_led = led; o_dir = dir; o_cnt = cnt; o_tick = 0;
        if (ld != 0 || ms != prev) begin
            o_led = bs; o_dir = 0; o_cnt = 0;
        end else begin
            if (e != 0) begin
                o_cnt = (cnt + 1) % TICK_DIV;
                if (cnt == TICK_DIV - 1) o_tick = 1;
            end
            if (ms == 0) begin
                o_led = bs;
            end else if (o_tick == 1) begin
                case (ms)
                    1: o_led = (led * 2) % FULL + led / TOP;
                    2: begin
                        if (dir == 0) begin
                            if (led >= TOP) begin o_dir = 1; o_led = led / 2; end
                            else o_led = (led * 2) % FULL;
                        end else begin
                            if (led % 2 == 1) begin o_dir = 0; o_led = (led * 2) % FULL; end
                            else o_led = led / 2;
                        end
                    end
                    default: o_led = FULL - 1 - led;
                endcase
            end
        end
    endfunction

    always_comb begin
        n_led = 0; n_dir = 0; n_cnt = 0; n_tick = 0;
        model_next(m_led, m_dir, m_cnt, m_mode_b, m_base_b, int'(load), int'(en),
                   m_mode_prev, n_led, n_dir, n_cnt, n_tick);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_led <= 0; m_dir <= 0; m_cnt <= 0; m_tick <= 0;
            m_mode_a <= 0; m_mode_b <= 0; m_mode_prev <= 0;
            m_base_a <= 0; m_base_b <= 0;
        end else begin
            m_led <= n_led; m_dir <= n_dir; m_cnt <= n_cnt; m_tick <= n_tick;
            m_mode_prev <= m_mode_b;
            m_mode_b <= m_mode_a;
            m_mode_a <= int'(mode);
            m_base_b <= m_base_a;
            m_base_a <= int'(base);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            n_total++;
            if (LED === WIDTH'(m_led)) n_pass++;
            else $display("FAIL model_led t=%0t got=%b exp=%b", $time, LED, WIDTH'(m_led));
            n_total++;
            if (tick === (m_tick != 0)) n_pass++;
            else $display("FAIL model_tick t=%0t got=%b exp=%0d", $time, tick, m_tick);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    // Wait for the next tick pulse, sampled 1 time unit after each edge
    task automatic wait_tick(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (tick === 1'b1) return;
        end
        n_total++;
        $display("FAIL wait_tick timeout got=no_tick exp=tick_within_40");
        cycles = -1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c;
    int pp_exp[7] = '{2, 4, 8, 4, 2, 1, 2};
    int rot_exp[4] = '{2, 4, 8, 1};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_led", int'(LED), 0);
        chk("reset_tick", int'(tick), 0);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // STATIC tracking with three-edge switch latency
        rst_n = 1'b1; en = 1'b1; mode = 2'b00; base = 4'b1010;
        edges(2);
        chk("static_lat2", int'(LED), 0);
        edges(1);
        chk("static_1010", int'(LED), 10);
        @(negedge clk) base = 4'b0101;
        edges(2);
        chk("static_hold", int'(LED), 10);
        edges(1);
        chk("static_0101", int'(LED), 5);
        wait_tick(c);
        wait_tick(c);
        chk("static_tick_period", c, 4);
        wait_tick(c);
        chk("static_tick_period2", c, 4);

        // ROTATE after a mode-change reload
        @(negedge clk) begin mode = 2'b01; base = 4'b0001; end
        edges(2);
        chk("rot_prereload", int'(LED), 5);
        edges(1);
        chk("rot_reload", int'(LED), 1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(c);
            chk("rot_step", int'(LED), rot_exp[i]);
            chk("rot_period", c, 4);
        end

        // PINGPONG walk and bounce
        @(negedge clk) mode = 2'b10;
        edges(3);
        chk("pp_reload", int'(LED), 1);
        for (int i = 0; i < 7; i++) begin
            wait_tick(c);
            chk("pp_step", int'(LED), pp_exp[i]);
        end

        // BLINK with an en=0 freeze mid-count
        @(negedge clk) begin mode = 2'b11; base = 4'b1010; end
        edges(3);
        chk("blink_reload", int'(LED), 10);
        wait_tick(c);
        chk("blink_1", int'(LED), 5);
        wait_tick(c);
        chk("blink_2", int'(LED), 10);
        edges(1);
        @(negedge clk) en = 1'b0;
        edges(6);
        chk("freeze_led", int'(LED), 10);
        chk("freeze_tick", int'(tick), 0);
        @(negedge clk) en = 1'b1;
        wait_tick(c);
        chk("resume_remaining", c, 3);
        chk("resume_led", int'(LED), 5);

        // ROTATE with load on the wrap cycle
        @(negedge clk) begin mode = 2'b01; base = 4'b0001; end
        edges(3);
        chk("rot2_reload", int'(LED), 1);
        wait_tick(c);
        wait_tick(c);
        chk("rot2_0100", int'(LED), 4);
        repeat (3) @(posedge clk);
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        chk("load_beats_step", int'(LED), 1);
        chk("load_no_tick", int'(tick), 0);
        wait_tick(c);
        chk("load_restart_period", c, 4);
        chk("load_next_step", int'(LED), 2);

        // Asynchronous reset in the middle of ROTATE
        wait_tick(c);
        chk("pre_reset_led", int'(LED), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_led", int'(LED), 0);
        chk("async_reset_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edges(1);
        chk("post_reset_e1", int'(LED), 0);
        edges(1);
        chk("post_reset_e2", int'(LED), 0);
        edges(1);
        chk("post_reset_reload", int'(LED), 1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) base = 4'($urandom_range(0, 15));
            load = ($urandom_range(0, 29) == 0);
            en   = ($urandom_range(0, 7) != 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        @(negedge clk) begin load = 1'b0; en = 1'b1; end
        @(negedge clk);
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
